// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs and pipeline register controls.
// Purely wires; no storage.
// No flow control; the controller answers combinationally every cycle.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  // Hazard sources seen by the controller
  logic [4:0]        id_rs_i;
  logic [4:0]        id_rt_i;
  logic              id_uses_rt_i;
  logic              id_mul_i;
  logic              ex_mem_read_i;
  logic [4:0]        ex_rd_i;
  logic              ex_redirect_i;
  logic              ext_stall_i;
  // Pipeline controls produced by the controller
  logic              pc_keep_o;
  logic              if_id_keep_o;
  logic              if_id_flush_o;
  logic              id_ex_bubble_o;
  logic              mul_busy_o;
  logic [PERF_W-1:0] stall_cnt_o;
  logic [PERF_W-1:0] flush_cnt_o;

  // Pipeline side: supplies hazard information, consumes controls
  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, id_mul_i,
           ex_mem_read_i, ex_rd_i, ex_redirect_i, ext_stall_i,
    input  pc_keep_o, if_id_keep_o, if_id_flush_o, id_ex_bubble_o,
           mul_busy_o, stall_cnt_o, flush_cnt_o
  );

  // Controller side
  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, id_mul_i,
           ex_mem_read_i, ex_rd_i, ex_redirect_i, ext_stall_i,
    output pc_keep_o, if_id_keep_o, if_id_flush_o, id_ex_bubble_o,
           mul_busy_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: PC hold, IF/ID keep/flush, ID/EX bubble, perf counters.
// Controls are combinational (same cycle); state/counters update on the rising edge.
// ext_stall_i freezes everything; a mul/div holds the front end for MUL_LAT-1 cycles.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4,
  parameter int PERF_W  = 16
) (
  input logic          clk_i,
  input logic          rst_n_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;
  logic              lu;
  logic              pc_keep, if_id_keep, if_id_flush, id_ex_bubble, mul_busy;

  // Load-use: EX load writes a register the ID instruction reads ($0 never hazards)
  always_comb begin
    lu = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
         ((hz.ex_rd_i == hz.id_rs_i) ||
          (hz.id_uses_rt_i && (hz.ex_rd_i == hz.id_rt_i)));
  end

  // Priority-ordered control decode and next-state logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_keep      = 1'b0;
    if_id_keep   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mul_busy     = (state == MUL_WAIT);
    if (hz.ext_stall_i) begin
      // Whole front end frozen; the mul wait stretches one for one
      pc_keep    = 1'b1;
      if_id_keep = 1'b1;
    end else if (state == MUL_WAIT) begin
      // Mul occupies EX: redirects and load-use cannot originate there
      pc_keep      = 1'b1;
      if_id_keep   = 1'b1;
      id_ex_bubble = 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end else if (hz.ex_redirect_i) begin
      // PC loads the target; IF/ID and ID hold wrong-path instructions
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      pc_keep      = 1'b1;
      if_id_keep   = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hz.id_mul_i) begin
      // Entry cycle lets the mul advance into EX; stalls start next cycle
      state_nxt = MUL_WAIT;
      cnt_nxt   = CNT_INIT;
    end
  end

  // State and wait counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating stall/flush performance counters
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_keep && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign hz.pc_keep_o      = pc_keep;
  assign hz.if_id_keep_o   = if_id_keep;
  assign hz.if_id_flush_o  = if_id_flush;
  assign hz.id_ex_bubble_o = id_ex_bubble;
  assign hz.mul_busy_o     = mul_busy;
  assign hz.stall_cnt_o    = stall_cnt;
  assign hz.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycles push expected controls and counters,
// a negedge monitor pops and compares against the DUT outputs.
// Inputs change 1ns after the rising edge.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.PERF_W(16)) hif ();

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(4), .PERF_W(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .hz      (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl bit order: {pc_keep, if_id_keep, if_id_flush, id_ex_bubble, mul_busy}
  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_st;
  logic [15:0] exp_fl;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Compare each expected entry in the cycle it was driven
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_keep",  32'(hif.pc_keep_o),      32'(e.ctl[4]));
      chk("if_keep",  32'(hif.if_id_keep_o),   32'(e.ctl[3]));
      chk("if_flush", 32'(hif.if_id_flush_o),  32'(e.ctl[2]));
      chk("bubble",   32'(hif.id_ex_bubble_o), 32'(e.ctl[1]));
      chk("mul_busy", 32'(hif.mul_busy_o),     32'(e.ctl[0]));
      chk("stall_cnt", 32'(hif.stall_cnt_o),   32'(e.st));
      chk("flush_cnt", 32'(hif.flush_cnt_o),   32'(e.fl));
    end
  end

  task automatic idle();
    hif.id_rs_i       = 5'd0;
    hif.id_rt_i       = 5'd0;
    hif.id_uses_rt_i  = 1'b0;
    hif.id_mul_i      = 1'b0;
    hif.ex_mem_read_i = 1'b0;
    hif.ex_rd_i       = 5'd0;
    hif.ex_redirect_i = 1'b0;
    hif.ext_stall_i   = 1'b0;
  endtask

  // One clock with the current inputs; e is the expected control vector
  task automatic step(input logic [4:0] e);
    exp_t x;
    x.ctl = e;
    x.st  = exp_st;
    x.fl  = exp_fl;
    sb.push_back(x);
    if (e[4] && exp_st != 16'hFFFF) exp_st = exp_st + 16'd1;
    if (e[2] && exp_fl != 16'hFFFF) exp_fl = exp_fl + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_st = 16'd0;
    exp_fl = 16'd0;
  endtask

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11010;
  localparam logic [4:0] MULW  = 5'b11011;
  localparam logic [4:0] FLUSH = 5'b00110;
  localparam logic [4:0] EXT   = 5'b11000;
  localparam logic [4:0] EXTM  = 5'b11001;

  initial begin
    exp_st = 16'd0;
    exp_fl = 16'd0;
    idle();
    @(posedge clk);
    #1;
    do_reset(2);
    step(NONE);

    // Load-use via rs, then rd=0 (no hazard), then rt with/without uses_rt
    hif.ex_mem_read_i = 1'b1; hif.ex_rd_i = 5'd8; hif.id_rs_i = 5'd8;
    step(STALL);
    idle(); step(NONE);
    hif.ex_mem_read_i = 1'b1; hif.ex_rd_i = 5'd0; hif.id_rs_i = 5'd0;
    step(NONE);
    hif.ex_rd_i = 5'd9; hif.id_rs_i = 5'd1; hif.id_rt_i = 5'd9; hif.id_uses_rt_i = 1'b1;
    step(STALL);
    hif.id_uses_rt_i = 1'b0;
    step(NONE);
    hif.ex_mem_read_i = 1'b0; hif.id_rs_i = 5'd9;
    step(NONE);
    idle();

    // Mul: entry without stall, then three wait cycles
    hif.id_mul_i = 1'b1;
    step(NONE);
    hif.id_mul_i = 1'b0;
    repeat (3) step(MULW);
    step(NONE);

    // Mul with two external stall cycles inside the wait
    hif.id_mul_i = 1'b1;
    step(NONE);
    hif.id_mul_i = 1'b0;
    step(MULW);
    hif.ext_stall_i = 1'b1;
    step(EXTM);
    step(EXTM);
    hif.ext_stall_i = 1'b0;
    step(MULW);
    step(MULW);
    step(NONE);

    // Redirect beats a simultaneous load-use
    hif.ex_redirect_i = 1'b1; hif.ex_mem_read_i = 1'b1; hif.ex_rd_i = 5'd8; hif.id_rs_i = 5'd8;
    step(FLUSH);
    idle(); step(NONE);

    // Redirect during mul wait is ignored
    hif.id_mul_i = 1'b1;
    step(NONE);
    hif.id_mul_i = 1'b0; hif.ex_redirect_i = 1'b1;
    step(MULW);
    hif.ex_redirect_i = 1'b0;
    step(MULW);
    step(MULW);
    step(NONE);

    // External stall beats redirect; redirect takes effect once released
    hif.ext_stall_i = 1'b1; hif.ex_redirect_i = 1'b1;
    step(EXT);
    hif.ext_stall_i = 1'b0;
    step(FLUSH);
    idle(); step(NONE);

    // Saturate the stall counter
    hif.ext_stall_i = 1'b1;
    repeat (65540) step(EXT);
    chk("stall_sat", 32'(hif.stall_cnt_o), 32'h0000_FFFF);
    hif.ext_stall_i = 1'b0;
    step(NONE);

    // Reset while in MUL_WAIT with cnt==2
    hif.id_mul_i = 1'b1;
    step(NONE);
    hif.id_mul_i = 1'b0;
    step(MULW);
    do_reset(1);
    step(NONE);
    step(NONE);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Generates the PC hold, IF/ID hold/flush and ID/EX bubble controls from load-use dependencies, taken branches/jumps, a multi-cycle multiply/divide unit and an external memory wait. It also keeps saturating stall/flush performance counters. It sits beside the ID stage and drives the PC register, the IF/ID pipeline register and the ID/EX pipeline register.

## Interface
- `MUL_LAT`, 4: total EX occupancy of a mul/div instruction in cycles; legal range 2..15.
- `CNT_W`, 4: width of the mul/div wait counter; must hold `MUL_LAT-1`.
- `PERF_W`, 16: width of the performance counters.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; synchronous and active-low.
- `id_rs_i`  in  5  rs field of the instruction in ID.
- `id_rt_i`  in  5  rt field of the instruction in ID.
- `id_uses_rt_i`  in  1  ID instruction reads rt as a source.
- `id_mul_i`  in  1  ID instruction is a mul/div (multi-cycle).
- `ex_mem_read_i`  in  1  EX instruction is a load.
- `ex_rd_i`  in  5  destination register of the EX instruction.
- `ex_redirect_i`  in  1  taken branch or jump resolved in EX this cycle.
- `ext_stall_i`  in  1  memory not ready; freeze the whole front end.
- `pc_keep_o`  out  1  hold PC.
- `if_id_keep_o`  out  1  drives IF/ID `keep_d`.
- `if_id_flush_o`  out  1  drives IF/ID `flush_d`.
- `id_ex_bubble_o`  out  1  inject a NOP into ID/EX.
- `mul_busy_o`  out  1  controller is in MUL_WAIT.
- `stall_cnt_o`  out  PERF_W  saturating count of cycles with `pc_keep_o`=1.
- `flush_cnt_o`  out  PERF_W  saturating count of cycles with `if_id_flush_o`=1.

## Operation
- States: RUN (0) and MUL_WAIT (1). Registers: state, wait counter `cnt`, and the two perf counters.
- Reset (`rst_n_i`=0 at a rising edge): state=RUN, cnt=0, both perf counters=0. This applies mid-MUL_WAIT too; no pending stall survives reset.
- Load-use hazard `lu` = `ex_mem_read_i` & (`ex_rd_i`!=0) & ((`ex_rd_i`==`id_rs_i`) | (`id_uses_rt_i` & `ex_rd_i`==`id_rt_i`)).
- Outputs are combinational from state and inputs. Evaluate in this priority order; the first match wins.
  1. `ext_stall_i`: `pc_keep`=1, `if_id_keep`=1, `flush`=0, `bubble`=0. State and cnt hold. The redirect source must hold `ex_redirect_i` stable while it is stalled.
  2. MUL_WAIT: `pc_keep`=1, `if_id_keep`=1, `bubble`=1, `flush`=0, `mul_busy`=1. If cnt==1, go to RUN; else decrement cnt. `ex_redirect_i`, `lu` and `id_mul_i` are ignored, because a mul occupies EX.
  3. RUN & `ex_redirect_i`: `flush`=1, `bubble`=1, `keep`=0, `pc_keep`=0 (the PC loads the target). Any `lu` or `id_mul_i` is discarded as wrong-path.
  4. RUN & `lu`: `pc_keep`=1, `if_id_keep`=1, `bubble`=1 for this cycle only. State stays RUN.
  5. RUN & `id_mul_i`: no stall this cycle, so the mul advances to EX. Go to MUL_WAIT with cnt=`MUL_LAT`-1.
  6. Otherwise: all outputs 0.
- Invariant: `if_id_keep_o` and `if_id_flush_o` are never both 1. IF/ID gives keep priority, so asserting both would lose a flush.
- Perf counters: increment by 1 on each rising edge where the corresponding output is 1. They saturate at all-ones with no wrap. They count during `ext_stall_i`.

## Timing
- The state machine advances on the rising edge of `clk_i`. Outputs settle in the first half-cycle and are sampled by the falling-edge pipeline registers in the same cycle.
- Load-use: 1 stall cycle. Redirect: 1 flush cycle, so the branch penalty is 2 instructions (IF and ID squashed).
- Mul/div: entry cycle has no stall, followed by exactly `MUL_LAT`-1 stall cycles. `ext_stall_i` during MUL_WAIT extends the wait 1:1.
- All outputs are 0 during and immediately after reset when inputs are idle.

## Test plan
- Reset: hold `rst_n_i`=0 for 2 cycles with all inputs 0, then release -> all outputs 0, `stall_cnt`=`flush_cnt`=0.
- Load-use: `ex_mem_read_i`=1, `ex_rd_i`=8, `id_rs_i`=8 for 1 cycle -> `pc_keep`/`if_id_keep`/`bubble`=1 for 1 cycle, `stall_cnt`=1. Repeat with `ex_rd_i`=0 -> no stall.
- Mul with `MUL_LAT`=4: `id_mul_i` pulse -> entry cycle has no stall, then exactly 3 cycles of `mul_busy`=1 and `keep`=1, then RUN. Raise `ext_stall_i` for 2 cycles mid-wait -> 5 keep cycles total.
- Redirect: `ex_redirect_i`=1 together with `lu`=1 -> `flush`=1, `bubble`=1, `keep`=0, `flush_cnt`+1. Issuing `ex_redirect_i` in MUL_WAIT -> ignored.
- Priority: `ext_stall_i`=1 together with `ex_redirect_i`=1 -> keep=1, flush=0. Drop `ext_stall_i` -> flush=1 in that cycle.
- Saturation and reset mid-operation: preload by running 65540 stall cycles -> `stall_cnt`=0xFFFF held. Assert reset in MUL_WAIT with cnt=2 -> next cycle RUN, `mul_busy`=0, counters 0.
